// File: rtl/speed_lane_if.sv
// Lane-side signal bundle for speed_lane_ctrl: sensor/E-pass/enable inputs
// and the speed/barrier/status outputs that feed the reporting path.
interface speed_lane_if #(
    parameter int WIDTH_SPEED = 14
);
    logic                   sensor1;
    logic                   sensor2;
    logic                   sensor3;
    logic [1:0]             valid_Epass;
    logic                   enable;
    logic [WIDTH_SPEED-1:0] speed;
    logic                   speed_valid;
    logic                   overspeed;
    logic                   barrier;
    logic                   timeout_err;
    logic                   reject;
    logic                   busy;

    modport master (
        output sensor1, sensor2, sensor3, valid_Epass, enable,
        input  speed, speed_valid, overspeed, barrier, timeout_err, reject, busy
    );

    modport slave (
        input  sensor1, sensor2, sensor3, valid_Epass, enable,
        output speed, speed_valid, overspeed, barrier, timeout_err, reject, busy
    );
endinterface

// File: rtl/speed_lane_ctrl.sv
// Per-lane speed/toll gate controller. Times sensor1->sensor2 in 1 ms ticks,
// divides DIST_CM*360 by the elapsed ms (restoring, one bit per cycle) to get
// speed in 0.1 km/h, checks the E-pass verdict and drives the barrier.
// Optional build macro SPEED_LANE_OVERSPEED_LOCK_EN: an overspeeding vehicle
// with a valid E-pass is rejected instead of let through.
module speed_lane_ctrl #(
    parameter int SYS_FREQ    = 50000000,
    parameter int WIDTH_MS    = 12,
    parameter int WIDTH_SPEED = 14,
    parameter int DIST_CM     = 400,
    parameter int SPEED_LIMIT = 600,
    parameter int TIMEOUT_MS  = 3000
) (
    input  logic        clk,
    input  logic        reset_n,
    speed_lane_if.slave lane
);
    localparam int PRE_MAX = SYS_FREQ / 1000 - 1;
    localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
    localparam int NUM     = DIST_CM * 360;
    localparam int NUM_W   = $clog2(NUM + 1);
    localparam int CNT_W   = $clog2(NUM_W + 1);

    localparam logic [31:0]            SPD_MAX = 32'((64'd1 << WIDTH_SPEED) - 1);
    localparam logic [WIDTH_MS-1:0]    TMO     = WIDTH_MS'(TIMEOUT_MS);
    localparam logic [WIDTH_SPEED-1:0] LIMIT   = WIDTH_SPEED'(SPEED_LIMIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TIMING = 3'd1;
    localparam logic [2:0] S_DIVIDE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_OPEN   = 3'd4;

    logic [2:0] state;

    // ---------------- sensor synchronisers + rise detect ----------------
    logic [2:0] sens_in;
    logic [2:0] rise;
    assign sens_in = {lane.sensor3, lane.sensor2, lane.sensor1};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        logic [2:0] sh;
        // two sync flops plus one history flop for edge detection
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sh <= '0;
            else          sh <= {sh[1:0], sens_in[i]};
        end
        assign rise[i] = sh[1] & ~sh[2];
    end

    // ---------------- ms prescaler / counter ----------------
    logic [PRE_W-1:0]    pre;
    logic [WIDTH_MS-1:0] ms, ms_next;
    logic                tick, start_timing, div_done;

    assign tick         = (pre == PRE_W'(PRE_MAX));
    assign ms_next      = (tick && ms != '1) ? ms + 1'b1 : ms;
    assign start_timing = (state == S_IDLE) && rise[0] && lane.enable;

    // prescaler restarts with each vehicle so the first ms is a full ms
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 pre <= '0;
        else if (start_timing || tick) pre <= '0;
        else                          pre <= pre + 1'b1;
    end

    // saturating ms counter, cleared at vehicle start and after the divide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     ms <= '0;
        else if (start_timing || div_done) ms <= '0;
        else                              ms <= ms_next;
    end

    // ---------------- restoring divider datapath ----------------
    logic [WIDTH_MS-1:0]    div_d, rem, rem_next;
    logic [NUM_W-1:0]       num_sh, quo, quo_next;
    logic [CNT_W-1:0]       cnt;
    logic [WIDTH_MS:0]      rem_sh;
    logic                   sub_ok;
    logic [WIDTH_SPEED-1:0] spd_sat;

    assign rem_sh   = {rem, num_sh[NUM_W-1]};
    assign sub_ok   = (rem_sh >= {1'b0, div_d});
    assign rem_next = sub_ok ? WIDTH_MS'(rem_sh - {1'b0, div_d}) : WIDTH_MS'(rem_sh);
    assign quo_next = {quo[NUM_W-2:0], sub_ok};
    assign div_done = (state == S_DIVIDE) && (cnt == CNT_W'(NUM_W - 1));
    assign spd_sat  = (32'(quo_next) > SPD_MAX) ? '1 : WIDTH_SPEED'(quo_next);

    // ---------------- E-pass decode ----------------
    logic overspeed_q;
    logic epass_ok, epass_rej;
`ifdef SPEED_LANE_OVERSPEED_LOCK_EN
    assign epass_ok  = (lane.valid_Epass == 2'b01) && !overspeed_q;
    assign epass_rej = (lane.valid_Epass == 2'b10) ||
                       ((lane.valid_Epass == 2'b01) && overspeed_q);
`else
    assign epass_ok  = (lane.valid_Epass == 2'b01);
    assign epass_rej = (lane.valid_Epass == 2'b10);
`endif

    // ---------------- FSM, divider steps and registered outputs ----------------
    logic [WIDTH_SPEED-1:0] speed_q;
    logic                   speed_valid_q, barrier_q, timeout_q, reject_q;

    // lane sequencing; pulses default low every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            div_d         <= '0;
            rem           <= '0;
            num_sh        <= '0;
            quo           <= '0;
            cnt           <= '0;
            speed_q       <= '0;
            speed_valid_q <= 1'b0;
            overspeed_q   <= 1'b0;
            barrier_q     <= 1'b0;
            timeout_q     <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            speed_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            reject_q      <= 1'b0;
            case (state)
                S_IDLE: if (start_timing) state <= S_TIMING;
                S_TIMING: begin
                    if (rise[1]) begin
                        // include this cycle's tick; ms=0 would divide by zero
                        div_d  <= (ms_next == '0) ? WIDTH_MS'(1) : ms_next;
                        rem    <= '0;
                        num_sh <= NUM_W'(NUM);
                        quo    <= '0;
                        cnt    <= '0;
                        state  <= S_DIVIDE;
                    end else if (ms >= TMO) begin
                        timeout_q <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_DIVIDE: begin
                    rem    <= rem_next;
                    num_sh <= num_sh << 1;
                    quo    <= quo_next;
                    cnt    <= cnt + 1'b1;
                    if (div_done) begin
                        speed_q       <= spd_sat;
                        speed_valid_q <= 1'b1;
                        overspeed_q   <= (spd_sat > LIMIT);
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (epass_ok) begin
                        barrier_q <= 1'b1;
                        state     <= S_OPEN;
                    end else if (epass_rej) begin
                        reject_q <= 1'b1;
                        state    <= S_IDLE;
                    end else if (ms >= TMO) begin
                        timeout_q <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_OPEN: begin
                    if (rise[2]) begin
                        barrier_q <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign lane.speed       = speed_q;
    assign lane.speed_valid = speed_valid_q;
    assign lane.overspeed   = overspeed_q;
    assign lane.barrier     = barrier_q;
    assign lane.timeout_err = timeout_q;
    assign lane.reject      = reject_q;
    assign lane.busy        = (state != S_IDLE);
endmodule

// File: tb/tb_speed_lane_ctrl.sv
// Bench for speed_lane_ctrl: table of vehicles (gap, E-pass, expected result)
// with a speed scoreboard, plus hand sequences for saturation, timeout,
// reset with barrier open and lane disable. 10 clocks per ms keeps it short.
`timescale 1ns/1ps
module tb_speed_lane_ctrl;
    localparam int SYS_FREQ = 10000;
    localparam int CPM      = SYS_FREQ / 1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    speed_lane_if #(.WIDTH_SPEED(14)) lane ();

    speed_lane_ctrl #(
        .SYS_FREQ(SYS_FREQ), .WIDTH_MS(12), .WIDTH_SPEED(14),
        .DIST_CM(400), .SPEED_LIMIT(600), .TIMEOUT_MS(3000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .lane(lane)
    );

    typedef struct {
        int         gap_ms;
        logic [1:0] epass;
        int         exp_speed;
        logic       exp_over;
        logic       exp_barrier;
        logic       exp_reject;
    } vec_t;

    typedef struct {
        logic [13:0] spd;
        logic        over;
    } sb_t;

    int  checks = 0;
    int  failures = 0;
    sb_t sb_q[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: every speed_valid pulse must match the oldest expectation
    logic sv_prev = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (lane.speed_valid) begin
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected: got speed %0d expected no update", lane.speed);
            end else begin
                e = sb_q.pop_front();
                check("sb_speed", 32'(lane.speed), 32'(e.spd));
                check("sb_over", 32'(lane.overspeed), 32'(e.over));
            end
            if (sv_prev) begin
                checks++; failures++;
                $display("FAIL speed_valid_width: got 2+ cycles expected 1");
            end
        end
        sv_prev = lane.speed_valid;
    end

    task automatic wait_sb();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        check("sb_drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    // sensor1 rise, sensor2 rise gap_ms later, wait for the speed result
    task automatic start_vehicle(input int gap_ms, input int exp_speed, input logic exp_over);
        sb_t e;
        @(posedge clk); #1 lane.sensor1 = 1'b1;
        repeat (5) @(posedge clk);
        #1 lane.sensor1 = 1'b0;
        repeat (gap_ms * CPM - 5) @(posedge clk);
        #1 lane.sensor2 = 1'b1;
        e.spd  = 14'(exp_speed);
        e.over = exp_over;
        sb_q.push_back(e);
        wait_sb();
        check("busy_wait_pass", 32'(lane.busy), 1);
        lane.sensor2 = 1'b0;
    endtask

    task automatic run_vehicle(input vec_t v);
        start_vehicle(v.gap_ms, v.exp_speed, v.exp_over);
        @(posedge clk); #1 lane.valid_Epass = 2'b11;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("epass11_barrier", 32'(lane.barrier), 0);
        check("epass11_busy", 32'(lane.busy), 1);
        @(posedge clk); #1 lane.valid_Epass = v.epass;
        @(posedge clk); @(negedge clk);
        check("verdict_barrier", 32'(lane.barrier), 32'(v.exp_barrier));
        check("verdict_reject", 32'(lane.reject), 32'(v.exp_reject));
        @(posedge clk); #1 lane.valid_Epass = 2'b00;
        @(negedge clk);
        check("reject_pulse_end", 32'(lane.reject), 0);
        if (v.exp_barrier) begin
            check("open_busy", 32'(lane.busy), 1);
            @(posedge clk); #1 lane.sensor3 = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (!lane.barrier) break;
            end
            check("close_barrier", 32'(lane.barrier), 0);
            check("close_busy", 32'(lane.busy), 0);
            lane.sensor3 = 1'b0;
        end else begin
            check("reject_busy", 32'(lane.busy), 0);
        end
        repeat (5) @(posedge clk);
    endtask

    // hang guard
    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic hit;
        vecs[0] = '{640, 2'b01, 225,   1'b0, 1'b1, 1'b0};
        vecs[1] = '{641, 2'b01, 224,   1'b0, 1'b1, 1'b0};
`ifdef SPEED_LANE_OVERSPEED_LOCK_EN
        vecs[2] = '{200, 2'b01, 720,   1'b1, 1'b0, 1'b1};
`else
        vecs[2] = '{200, 2'b01, 720,   1'b1, 1'b1, 1'b0};
`endif
        vecs[3] = '{480, 2'b10, 300,   1'b0, 1'b0, 1'b1};
        vecs[4] = '{240, 2'b01, 600,   1'b0, 1'b1, 1'b0};
        vecs[5] = '{7,   2'b10, 16383, 1'b1, 1'b0, 1'b1};

        lane.sensor1 = 0; lane.sensor2 = 0; lane.sensor3 = 0;
        lane.valid_Epass = 2'b00; lane.enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_speed", 32'(lane.speed), 0);
        check("rst_barrier", 32'(lane.barrier), 0);
        check("rst_busy", 32'(lane.busy), 0);
        check("rst_over", 32'(lane.overspeed), 0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 6; i++) run_vehicle(vecs[i]);

        // simultaneous sensor1+sensor2 rise: sensor2 ignored, next sensor2 after 1 ms
        begin
            sb_t e;
            @(posedge clk); #1 lane.sensor1 = 1'b1; lane.sensor2 = 1'b1;
            repeat (5) @(posedge clk);
            #1 lane.sensor1 = 1'b0; lane.sensor2 = 1'b0;
            repeat (5) @(posedge clk);
            #1 lane.sensor2 = 1'b1;
            e.spd = 14'd16383; e.over = 1'b1;
            sb_q.push_back(e);
            wait_sb();
            lane.sensor2 = 1'b0;
            @(posedge clk); #1 lane.valid_Epass = 2'b10;
            @(posedge clk); @(negedge clk);
            check("sat_reject", 32'(lane.reject), 1);
            #1 lane.valid_Epass = 2'b00;
            repeat (5) @(posedge clk);
        end

        // no sensor2: timeout after 3000 ms
        @(posedge clk); #1 lane.sensor1 = 1'b1;
        n = 0; hit = 1'b0;
        while (n < 30100 && !hit) begin
            @(negedge clk);
            n++;
            if (n == 5) lane.sensor1 = 1'b0;
            if (lane.timeout_err) hit = 1'b1;
        end
        check("tmo_seen", 32'(hit), 1);
        check("tmo_window", 32'(n >= 30000 && n <= 30010), 1);
        check("tmo_speed_kept", 32'(lane.speed), 16383);
        @(negedge clk);
        check("tmo_pulse_end", 32'(lane.timeout_err), 0);
        check("tmo_idle", 32'(lane.busy), 0);

        // reset with barrier open
        start_vehicle(300, 480, 1'b0);
        @(posedge clk); #1 lane.valid_Epass = 2'b01;
        @(posedge clk); @(negedge clk);
        check("pre_rst_barrier", 32'(lane.barrier), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_barrier", 32'(lane.barrier), 0);
        check("async_rst_speed", 32'(lane.speed), 0);
        check("async_rst_over", 32'(lane.overspeed), 0);
        check("async_rst_busy", 32'(lane.busy), 0);
        lane.valid_Epass = 2'b00;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // lane disabled: sensor1 ignored
        #1 lane.enable = 1'b0; lane.sensor1 = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("disabled_busy", 32'(lane.busy), 0);
        lane.sensor1 = 1'b0; lane.enable = 1'b1;
        repeat (5) @(posedge clk);

        // sensor2 alone in IDLE is ignored
        #1 lane.sensor2 = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_s2_busy", 32'(lane.busy), 0);
        lane.sensor2 = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
